// File: rtl/prbs_chk.sv
// Receive-side PRBS checker for 128 independent lanes carrying the x^32 LFSR (taps 31,21,1,0).
// Every lane predicts its next bit from its own received history, so no seed exchange is needed.

module prbs_lane (
  input  logic ck,
  input  logic rst,
  input  logic i_acc,
  input  logic i_rx,
  output logic o_mis
);
  logic [31:0] r_h;

  // The received bit is shifted in, not the predicted one. This makes a flipped bit echo at +1, +2, +22 and +32.
  always_ff @(posedge ck or posedge rst) begin
    if (rst)        r_h <= '0;
    else if (i_acc) r_h <= {r_h[30:0], i_rx};
  end

  assign o_mis = i_rx ^ (r_h[31] ^ r_h[21] ^ r_h[1] ^ r_h[0]);
endmodule

module prbs_chk #(
  parameter int ERR_W       = 32,
  parameter int LOSS_THRESH = 8
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_vld,
  input  logic [63:0]      i_data_lower,
  input  logic [63:0]      i_data_upper,
  output logic             o_locked,
  output logic             o_err_vld,
  output logic [127:0]     o_err_lanes,
  output logic [ERR_W-1:0] o_bit_err_cnt,
  output logic [ERR_W-1:0] o_word_cnt,
  output logic [7:0]       o_lock_loss_cnt
);
  localparam int NUM_LANES = 128;
  localparam logic [ERR_W+7:0] BMAX = {8'b0, {ERR_W{1'b1}}};

  typedef enum logic {S_FILL, S_LOCKED} state_t;

  state_t                 r_state, w_state_nxt;
  logic [5:0]             r_fill, w_fill_nxt;
  logic [7:0]             r_cerr, w_cerr_nxt;
  logic                   w_loss;
  logic                   w_acc, w_chk;
  logic [NUM_LANES-1:0]   w_rx, w_mis;
  logic                   r_locked, r_err_vld;
  logic [NUM_LANES-1:0]   r_err_lanes;
  logic [ERR_W-1:0]       r_bit_cnt, r_word_cnt;
  logic [7:0]             r_loss_cnt;
  logic [7:0]             w_pop;
  logic [ERR_W+7:0]       w_bsum;

  assign w_rx  = {i_data_upper, i_data_lower};
  assign w_acc = i_vld & ~i_clr;
  assign w_chk = w_acc && (r_state == S_LOCKED);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    prbs_lane u_lane (
      .ck    (ck),
      .rst   (rst),
      .i_acc (w_acc),
      .i_rx  (w_rx[g]),
      .o_mis (w_mis[g])
    );
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_state  <= S_FILL;
      r_fill   <= '0;
      r_cerr   <= '0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_fill   <= w_fill_nxt;
      r_cerr   <= w_cerr_nxt;
      r_locked <= (w_state_nxt == S_LOCKED);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill;
    w_cerr_nxt  = r_cerr;
    w_loss      = 1'b0;
    if (i_clr) begin
      w_state_nxt = S_FILL;
      w_fill_nxt  = '0;
      w_cerr_nxt  = '0;
    end else if (w_acc) begin
      case (r_state)
        S_FILL: begin
          if (r_fill == 6'd31) begin
            w_state_nxt = S_LOCKED;
            w_fill_nxt  = '0;
          end else begin
            w_fill_nxt  = r_fill + 6'd1;
          end
        end
        S_LOCKED: begin
          if (|w_mis) begin
            if (r_cerr == 8'(LOSS_THRESH - 1)) begin
              w_state_nxt = S_FILL;
              w_fill_nxt  = '0;
              w_cerr_nxt  = '0;
              w_loss      = 1'b1;
            end else begin
              w_cerr_nxt  = r_cerr + 8'd1;
            end
          end else begin
            w_cerr_nxt = '0;
          end
        end
        default: w_state_nxt = S_FILL;
      endcase
    end
  end

  // Stage 1: the mismatch vector is strobed out. The lanes hold their last value while the strobe is low.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_err_vld   <= 1'b0;
      r_err_lanes <= '0;
      r_word_cnt  <= '0;
      r_loss_cnt  <= '0;
    end else if (i_clr) begin
      r_err_vld   <= 1'b0;
      r_word_cnt  <= '0;
      r_loss_cnt  <= '0;
    end else begin
      r_err_vld <= w_chk;
      if (w_chk) begin
        r_err_lanes <= w_mis;
        if (r_word_cnt != '1) r_word_cnt <= r_word_cnt + 1'b1;
      end
      if (w_loss && r_loss_cnt != 8'hFF) r_loss_cnt <= r_loss_cnt + 8'd1;
    end
  end

  always_comb begin
    w_pop = '0;
    for (int k = 0; k < NUM_LANES; k++) w_pop = w_pop + 8'(r_err_lanes[k]);
  end

  assign w_bsum = {8'b0, r_bit_cnt} + {{ERR_W{1'b0}}, w_pop};

  // Stage 2: popcount of the strobed vector. A clear drops any popcount already in flight.
  always_ff @(posedge ck or posedge rst) begin
    if (rst)            r_bit_cnt <= '0;
    else if (i_clr)     r_bit_cnt <= '0;
    else if (r_err_vld) r_bit_cnt <= (w_bsum > BMAX) ? '1 : w_bsum[ERR_W-1:0];
  end

  assign o_locked        = r_locked;
  assign o_err_vld       = r_err_vld;
  assign o_err_lanes     = r_err_lanes;
  assign o_bit_err_cnt   = r_bit_cnt;
  assign o_word_cnt      = r_word_cnt;
  assign o_lock_loss_cnt = r_loss_cnt;
endmodule

// File: tb/tb_prbs_chk.sv
// Random-stimulus bench for prbs_chk. A word-level reference model runs alongside,
// with a second instance (ERR_W=8) for the saturation cases.

module tb_prbs_chk;
  logic         ck = 1'b0, rst = 1'b1, i_clr = 1'b0, i_vld = 1'b0;
  logic [63:0]  lo = '0, hi = '0;
  logic         lk, ev, lk8, ev8;
  logic [127:0] el, el8;
  logic [31:0]  bc, wc;
  logic [7:0]   bc8, wc8, lc, lc8;

  prbs_chk u_dut (
    .ck(ck), .rst(rst), .i_clr(i_clr), .i_vld(i_vld),
    .i_data_lower(lo), .i_data_upper(hi),
    .o_locked(lk), .o_err_vld(ev), .o_err_lanes(el),
    .o_bit_err_cnt(bc), .o_word_cnt(wc), .o_lock_loss_cnt(lc)
  );

  prbs_chk #(.ERR_W(8), .LOSS_THRESH(8)) u_dut8 (
    .ck(ck), .rst(rst), .i_clr(i_clr), .i_vld(i_vld),
    .i_data_lower(lo), .i_data_upper(hi),
    .o_locked(lk8), .o_err_vld(ev8), .o_err_lanes(el8),
    .o_bit_err_cnt(bc8), .o_word_cnt(wc8), .o_lock_loss_cnt(lc8)
  );

  always #5 ck = ~ck;

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Reference model. Word-wide history: hist[k] is the word received k+1 accepted words ago.
  logic [127:0] m_hist [32];
  logic [127:0] g_hist [32];
  logic [127:0] m_elanes;
  bit           m_locked, m_evld;
  int           m_fill, m_cerr;
  longint       m_bits, m_words, m_loss;

  function automatic longint sat8(input longint v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] m_pred();
    return m_hist[0] ^ m_hist[1] ^ m_hist[21] ^ m_hist[31];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 32; k++) m_hist[k] = '0;
    m_elanes = '0; m_locked = 0; m_evld = 0;
    m_fill = 0; m_cerr = 0; m_bits = 0; m_words = 0; m_loss = 0;
  endtask

  task automatic gen(output logic [127:0] w);
    w = g_hist[0] ^ g_hist[1] ^ g_hist[21] ^ g_hist[31];
    for (int k = 31; k > 0; k--) g_hist[k] = g_hist[k-1];
    g_hist[0] = w;
  endtask

  task automatic check_all(input string sfx);
    chk({"locked", sfx}, lk, m_locked);
    chk({"err_vld", sfx}, ev, m_evld);
    chk({"err_lanes", sfx}, el, m_elanes);
    chk({"word_cnt", sfx}, wc, m_words);
    chk({"bit_cnt", sfx}, bc, m_bits);
    chk({"loss_cnt", sfx}, lc, m_loss);
    chk({"word_cnt8", sfx}, wc8, sat8(m_words));
    chk({"bit_cnt8", sfx}, bc8, sat8(m_bits));
    chk({"loss_cnt8", sfx}, lc8, sat8(m_loss));
  endtask

  task automatic step(input bit vld, input bit clr, input logic [127:0] d);
    logic [127:0] mis;
    longint nb;
    i_vld = vld; i_clr = clr; {hi, lo} = d;
    nb = m_bits + (m_evld ? longint'($countones(m_elanes)) : 0);
    if (clr) begin
      m_bits = 0; m_words = 0; m_loss = 0; m_cerr = 0; m_fill = 0;
      m_locked = 0; m_evld = 0;
    end else begin
      m_bits = nb;
      if (vld) begin
        mis = d ^ m_pred();
        m_evld = m_locked;
        if (m_locked) begin
          m_elanes = mis;
          m_words++;
          if (mis != '0) begin
            m_cerr++;
            if (m_cerr == 8) begin
              m_locked = 0; m_fill = 0; m_cerr = 0; m_loss++;
            end
          end else m_cerr = 0;
        end else begin
          m_fill++;
          if (m_fill == 32) begin m_locked = 1; m_fill = 0; end
        end
        for (int k = 31; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = d;
      end else m_evld = 0;
    end
    @(posedge ck); #1;
    check_all("");
  endtask

  task automatic send_gen(input int n, input bit gaps);
    logic [127:0] w;
    for (int i = 0; i < n; i++) begin
      while (gaps && $urandom_range(1) == 0) step(1'b0, 1'b0, rnd128());
      gen(w);
      step(1'b1, 1'b0, w);
    end
  endtask

  logic [31:0]  b0;
  logic [127:0] w;

  initial begin
    for (int k = 0; k < 32; k++) g_hist[k] = rnd128();
    model_reset();
    @(posedge ck); #1;
    check_all("_rst");
    rst = 1'b0;

    // Fill and lock, then a long clean run
    send_gen(31, 1'b0);
    chk("unlocked_w31", lk, 1'b0);
    send_gen(1, 1'b0);
    chk("locked_w32", lk, 1'b1);
    send_gen(1000, 1'b0);
    step(1'b0, 1'b0, rnd128());
    chk("clean_words", wc, 32'd1000);
    chk("clean_bits", bc, 32'd0);
    chk("word_sat8", wc8, 8'd255);

    // Single flipped bit in lane 5 produces five mismatches
    b0 = bc;
    send_gen(10, 1'b0);
    gen(w);
    step(1'b1, 1'b0, w ^ (128'd1 << 5));
    send_gen(40, 1'b0);
    step(1'b0, 1'b0, rnd128());
    chk("flip5_bits", bc - b0, 32'd5);
    chk("flip5_locked", lk, 1'b1);

    // Eight all-ones words force loss of lock
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '1);
    chk("loss_unlocked", lk, 1'b0);
    chk("loss_cnt1", lc, 8'd1);
    step(1'b0, 1'b0, rnd128());
    chk("bit_sat8", bc8, 8'd255);
    send_gen(32, 1'b0);
    chk("relock", lk, 1'b1);
    send_gen(20, 1'b0);

    // 7 errored, 1 clean, 7 errored: the run of errors is broken, so no loss
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, m_pred() ^ (128'd1 << $urandom_range(127)));
    step(1'b1, 1'b0, m_pred());
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, m_pred() ^ (128'd1 << $urandom_range(127)));
    chk("noloss_locked", lk, 1'b1);
    chk("noloss_cnt", lc, 8'd1);

    // Clear arriving with a valid word while a popcount is in flight
    step(1'b1, 1'b1, rnd128());
    chk("clr_locked", lk, 1'b0);
    chk("clr_words", wc, 32'd0);
    chk("clr_loss", lc, 8'd0);
    step(1'b0, 1'b0, rnd128());
    chk("clr_inflight_bits", bc, 32'd0);

    // Random valid gaps
    send_gen(32, 1'b1);
    chk("gap_relock", lk, 1'b1);
    send_gen(300, 1'b1);
    step(1'b0, 1'b0, rnd128());
    chk("gap_words", wc, 32'd300);
    chk("gap_bits", bc, 32'd0);

    // Asynchronous reset in the middle of LOCKED
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("_async_rst");
    @(posedge ck); #1;
    rst = 1'b0;
    send_gen(31, 1'b0);
    chk("rst_unlocked_w31", lk, 1'b0);
    send_gen(1, 1'b0);
    chk("rst_relock", lk, 1'b1);
    send_gen(5, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
